// File: rtl/minirisc_prog_sequencer_if.sv
// minirisc_prog_sequencer_if: opcode stream from the sequencer to the core's ui_in bus.
interface minirisc_prog_sequencer_if #(parameter int AW = 3);
    logic [7:0]    instr_out;
    logic          instr_valid;
    logic [AW-1:0] pc;
    logic          core_ready;
    modport master (output instr_out, instr_valid, pc, input core_ready);
    modport slave  (input instr_out, instr_valid, pc, output core_ready);
endinterface

// File: rtl/minirisc_prog_sequencer.sv
// minirisc_prog_sequencer: replays a buffered opcode program to the core with repeat passes, backpressure and illegal-opcode halt.
module minirisc_prog_sequencer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int LPW   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 prog_we,
    input  logic [AW-1:0]        prog_addr,
    input  logic [7:0]           prog_data,
    input  logic                 start,
    input  logic                 abort,
    input  logic [AW:0]          len,
    input  logic [LPW-1:0]       loops,
    minirisc_prog_sequencer_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_t         state, state_n;
    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  pc, pc_n, fetch_addr;
    logic [LPW-1:0] pass, pass_n, loops_q, loops_n;
    logic [AW:0]    len_q, len_n;
    logic [7:0]     out_q, out_n, op;
    logic           valid_q, valid_n, done_n, err_n, fetch, wr;

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        pass_n     = pass;
        len_n      = len_q;
        loops_n    = loops_q;
        out_n      = out_q;
        valid_n    = valid_q;
        done_n     = 1'b0;
        err_n      = err;
        fetch      = 1'b0;
        fetch_addr = '0;
        wr         = prog_we && state != RUN && !abort;
        if (abort) begin
            state_n = IDLE;
            valid_n = 1'b0;
            out_n   = 8'h00;
            pc_n    = '0;
        end else if (state != RUN) begin
            if (start) begin
                if (len == '0 || len > DEPTH_L) begin
                    err_n = 1'b1;
                end else begin
                    len_n   = len;
                    loops_n = loops;
                    err_n   = 1'b0;
                    pc_n    = '0;
                    pass_n  = '0;
                    fetch   = 1'b1;
                end
            end
        end else if (valid_q && bus.core_ready) begin
            if ({1'b0, pc} != len_q - 1'b1) begin
                pc_n       = pc + 1'b1;
                fetch_addr = pc + 1'b1;
                fetch      = 1'b1;
            end else if (pass < loops_q) begin
                pass_n = pass + 1'b1;
                pc_n   = '0;
                fetch  = 1'b1;
            end else begin
                state_n = IDLE;
                valid_n = 1'b0;
                out_n   = 8'h00;
                done_n  = 1'b1;
            end
        end
        // a same-cycle program write is forwarded so a run started with it sees the new opcode
        op = (wr && prog_addr == fetch_addr) ? prog_data : mem[fetch_addr];
        if (fetch) begin
            if (op <= 8'h04) begin
                out_n   = op;
                valid_n = 1'b1;
                state_n = RUN;
            end else begin
                out_n   = 8'h00;
                valid_n = 1'b0;
                err_n   = 1'b1;
                state_n = FAULT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= '0;
            pass    <= '0;
            len_q   <= '0;
            loops_q <= '0;
            out_q   <= 8'h00;
            valid_q <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
        end else if (ena) begin
            state   <= state_n;
            pc      <= pc_n;
            pass    <= pass_n;
            len_q   <= len_n;
            loops_q <= loops_n;
            out_q   <= out_n;
            valid_q <= valid_n;
            done    <= done_n;
            err     <= err_n;
            if (wr) mem[prog_addr] <= prog_data;
        end
    end

    assign bus.instr_out   = out_q;
    assign bus.instr_valid = valid_q;
    assign bus.pc          = pc;
    assign busy            = state == RUN;
endmodule

// File: tb/tb_minirisc_prog_sequencer.sv
// tb_minirisc_prog_sequencer: directed vectors with hand-computed expected opcode streams.
module tb_minirisc_prog_sequencer;
    logic       clk = 1'b0;
    logic       rst, ena, prog_we, start, abort, busy, done, err;
    logic [2:0] prog_addr;
    logic [7:0] prog_data;
    logic [3:0] len;
    logic [3:0] loops;
    int         n_chk = 0, n_ok = 0;
    logic [7:0] seen [$];

    minirisc_prog_sequencer_if #(.AW(3)) bus ();

    minirisc_prog_sequencer dut (
        .clk(clk), .rst(rst), .ena(ena), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .abort(abort), .len(len), .loops(loops),
        .bus(bus), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_ok++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic go(input logic [3:0] l, input logic [3:0] lp);
        len = l; loops = lp; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drain(input int budget, output int ticks, output int dones);
        seen.delete();
        ticks = 0; dones = 0;
        while (ticks < budget) begin
            if (bus.instr_valid && bus.core_ready) seen.push_back(bus.instr_out);
            tick();
            ticks++;
            if (done) begin dones++; break; end
        end
    endtask

    task automatic check_stream(input string tag, input logic [7:0] exp [$]);
        check({tag, "_n"}, seen.size(), exp.size());
        for (int i = 0; i < exp.size() && i < seen.size(); i++) check(tag, seen[i], exp[i]);
    endtask

    initial begin
        int t, d;
        rst = 1'b1; ena = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        start = 1'b0; abort = 1'b0; len = '0; loops = '0; bus.core_ready = 1'b1;
        @(negedge clk);
        tick(); tick();
        rst = 1'b0;
        check("rst_valid", bus.instr_valid, 0);
        check("rst_out", bus.instr_out, 0);
        check("rst_pc", bus.pc, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);

        // T1 plain pass
        wr(0, 8'h01); wr(1, 8'h02); wr(2, 8'h03); wr(3, 8'h04);
        go(4, 0);
        for (int i = 0; i < 4; i++) begin
            check("t1_out", bus.instr_out, i + 1);
            check("t1_pc", bus.pc, i);
            check("t1_busy", busy, 1);
            check("t1_nodone", done, 0);
            tick();
        end
        check("t1_done", done, 1);
        check("t1_valid", bus.instr_valid, 0);
        check("t1_busy_off", busy, 0);
        tick();
        check("t1_done_pulse", done, 0);

        // T2 backpressure while 02 shown
        go(4, 0);
        seen.delete();
        check("t2_first", bus.instr_out, 8'h01);
        tick();
        bus.core_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t2_hold_out", bus.instr_out, 8'h02);
            check("t2_hold_pc", bus.pc, 1);
            check("t2_hold_valid", bus.instr_valid, 1);
            tick();
        end
        bus.core_ready = 1'b1;
        drain(20, t, d);
        check("t2_done", d, 1);
        check_stream("t2_stream", '{8'h02, 8'h03, 8'h04});

        // T3 repeat passes, no bubbles
        go(2, 2);
        drain(30, t, d);
        check("t3_done", d, 1);
        check("t3_cycles", t, 6);
        check_stream("t3_stream", '{8'h01, 8'h02, 8'h01, 8'h02, 8'h01, 8'h02});
        tick();
        check("t3_done_pulse", done, 0);

        // T4 illegal opcode halts
        wr(2, 8'h07);
        go(4, 0);
        check("t4_o0", bus.instr_out, 8'h01);
        tick();
        check("t4_o1", bus.instr_out, 8'h02);
        tick();
        check("t4_valid", bus.instr_valid, 0);
        check("t4_out", bus.instr_out, 0);
        check("t4_err", err, 1);
        check("t4_busy", busy, 0);
        check("t4_done", done, 0);
        tick();
        check("t4_sticky", err, 1);
        wr(2, 8'h03);
        go(4, 0);
        check("t4_err_clr", err, 0);
        check("t4_restart", bus.instr_out, 8'h01);
        drain(20, t, d);
        check("t4_redone", d, 1);

        // T5 bad length, write-in-run, abort
        go(0, 0);
        check("t5_len_err", err, 1);
        check("t5_len_valid", bus.instr_valid, 0);
        check("t5_len_busy", busy, 0);
        go(9, 0);
        check("t5_len9_err", err, 1);
        go(4, 0);
        check("t5_ok_err", err, 0);
        tick();
        check("t5_pc1", bus.pc, 1);
        bus.core_ready = 1'b0;
        wr(3, 8'h02);
        bus.core_ready = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_ab_valid", bus.instr_valid, 0);
        check("t5_ab_out", bus.instr_out, 0);
        check("t5_ab_pc", bus.pc, 0);
        check("t5_ab_done", done, 0);
        check("t5_ab_busy", busy, 0);
        go(4, 0);
        drain(20, t, d);
        check_stream("t5_buf", '{8'h01, 8'h02, 8'h03, 8'h04});

        // T6 ena freeze mid-run
        go(4, 1);
        tick(); tick();
        check("t6_pre", bus.instr_out, 8'h03);
        ena = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t6_frz_out", bus.instr_out, 8'h03);
            check("t6_frz_pc", bus.pc, 2);
        end
        ena = 1'b1;
        drain(30, t, d);
        check("t6_done", d, 1);
        check_stream("t6_stream", '{8'h03, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04});

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end
endmodule
